// File: rtl/arith_issue_if.sv
// Issue-stage bus between decode/register-read (upstream) and the integer
// arithmetic/shift execute unit (downstream).
//   slave  : the issue stage itself (accepts instructions, presents packets)
//   master : the surrounding pipeline (offers instructions, consumes packets)
// Signals:
//   flush_i                               synchronous pipeline flush
//   instr_valid_i / instr_ready_o         upstream handshake
//   instr_i, rs1_data_i, rs2_data_i       raw instruction and register values
//   ex_valid_o / ex_ready_i               downstream handshake
//   ex_rs1_o, ex_rs2_o, ex_control_o,
//   ex_rd_o, ex_illegal_o                 issue packet toward execute
interface arith_issue_if #(
   parameter int bitWidth = 32
);
   logic                flush_i;
   logic                instr_valid_i;
   logic                instr_ready_o;
   logic [31:0]         instr_i;
   logic [bitWidth-1:0] rs1_data_i;
   logic [bitWidth-1:0] rs2_data_i;
   logic                ex_valid_o;
   logic                ex_ready_i;
   logic [bitWidth-1:0] ex_rs1_o;
   logic [bitWidth-1:0] ex_rs2_o;
   logic [10:0]         ex_control_o;
   logic [4:0]          ex_rd_o;
   logic                ex_illegal_o;

   modport slave (
      input  flush_i, instr_valid_i, instr_i, rs1_data_i, rs2_data_i, ex_ready_i,
      output instr_ready_o, ex_valid_o, ex_rs1_o, ex_rs2_o, ex_control_o,
             ex_rd_o, ex_illegal_o
   );

   modport master (
      output flush_i, instr_valid_i, instr_i, rs1_data_i, rs2_data_i, ex_ready_i,
      input  instr_ready_o, ex_valid_o, ex_rs1_o, ex_rs2_o, ex_control_o,
             ex_rd_o, ex_illegal_o
   );
endinterface

// File: rtl/arith_issue.sv
// arith_issue: decodes RV32I OP / OP-IMM instructions into the execute unit's
// 11-bit control word, selects operands (immediate substitution for OP-IMM)
// and registers the packet through a two-entry skid buffer (OR + SK).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   io       arith_issue_if.slave (handshakes, instruction, operands, packet)
module arith_issue #(
   parameter int bitWidth = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   arith_issue_if.slave io
);

   typedef struct packed {
      logic                illegal;
      logic [4:0]          rd;
      logic [10:0]         ctl;
      logic [bitWidth-1:0] rs2;
      logic [bitWidth-1:0] rs1;
   } pkt_t;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [10:0] C_ADD = 11'h041;
   localparam logic [10:0] C_SUB = 11'h042;
   localparam logic [10:0] C_AND = 11'h044;
   localparam logic [10:0] C_OR  = 11'h048;
   localparam logic [10:0] C_XOR = 11'h050;
   localparam logic [10:0] C_SLT = 11'h060;
   localparam logic [10:0] C_SLL = 11'h081;
   localparam logic [10:0] C_SRL = 11'h082;
   localparam logic [10:0] C_SRA = 11'h084;

   logic [6:0]          opcode, f7;
   logic [2:0]          f3;
   logic [10:0]         ctl;
   logic [bitWidth-1:0] op2, imm_s, imm_z;
   pkt_t                dec;

   assign opcode = io.instr_i[6:0];
   assign f3     = io.instr_i[14:12];
   assign f7     = io.instr_i[31:25];
   assign imm_s  = {{(bitWidth-12){io.instr_i[31]}}, io.instr_i[31:20]};
   assign imm_z  = {{(bitWidth-5){1'b0}}, io.instr_i[24:20]};

   // ctl stays zero for every unsupported encoding; zero doubles as "illegal".
   always_comb begin
      ctl = '0;
      op2 = io.rs2_data_i;
      case (opcode)
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  3'b000:  ctl = C_ADD;
                  3'b001:  ctl = C_SLL;
                  3'b010:  ctl = C_SLT;
                  3'b100:  ctl = C_XOR;
                  3'b101:  ctl = C_SRL;
                  3'b110:  ctl = C_OR;
                  3'b111:  ctl = C_AND;
                  default: ctl = '0;      // SLTU
               endcase
            end else if (f7 == F7_ALT) begin
               case (f3)
                  3'b000:  ctl = C_SUB;
                  3'b101:  ctl = C_SRA;
                  default: ctl = '0;
               endcase
            end
         end
         OPC_IMM: begin
            op2 = imm_s;
            case (f3)
               3'b000:  ctl = C_ADD;
               3'b010:  ctl = C_SLT;
               3'b100:  ctl = C_XOR;
               3'b110:  ctl = C_OR;
               3'b111:  ctl = C_AND;
               3'b001: begin
                  op2 = imm_z;
                  if (f7 == F7_BASE) ctl = C_SLL;
               end
               3'b101: begin
                  op2 = imm_z;
                  if (f7 == F7_BASE)     ctl = C_SRL;
                  else if (f7 == F7_ALT) ctl = C_SRA;
               end
               default: ctl = '0;         // SLTIU
            endcase
         end
         default: ctl = '0;
      endcase

      dec         = '0;
      dec.illegal = 1'b1;
      if (ctl != '0) begin
         dec.illegal = 1'b0;
         dec.rd      = io.instr_i[11:7];
         dec.ctl     = ctl;
         dec.rs1     = io.rs1_data_i;
         dec.rs2     = op2;
      end
   end

   // Skid buffer: OR drives execute, SK catches the one packet accepted while
   // OR is stalled. Ready depends only on SK state, so it is a flop output.
   pkt_t or_q, sk_q;
   logic or_vld, sk_vld;
   logic acc, or_free;

   assign acc     = io.instr_valid_i & ~sk_vld;
   assign or_free = ~or_vld | io.ex_ready_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         or_q   <= '0;
         sk_q   <= '0;
         or_vld <= 1'b0;
         sk_vld <= 1'b0;
      end else if (io.flush_i) begin
         or_vld <= 1'b0;
         sk_vld <= 1'b0;
      end else if (or_free) begin
         if (sk_vld) begin
            or_q   <= sk_q;
            or_vld <= 1'b1;
            sk_vld <= 1'b0;
         end else if (acc) begin
            or_q   <= dec;
            or_vld <= 1'b1;
         end else begin
            or_vld <= 1'b0;
         end
      end else if (acc) begin
         sk_q   <= dec;
         sk_vld <= 1'b1;
      end
   end

   assign io.instr_ready_o = ~sk_vld;
   assign io.ex_valid_o    = or_vld;
   assign io.ex_rs1_o      = or_q.rs1;
   assign io.ex_rs2_o      = or_q.rs2;
   assign io.ex_control_o  = or_q.ctl;
   assign io.ex_rd_o       = or_q.rd;
   assign io.ex_illegal_o  = or_q.illegal;

endmodule

// File: tb/tb_arith_issue.sv
// Scoreboard bench for arith_issue: the driver pushes the hand-computed packet
// when an instruction is accepted; a negedge monitor pops and compares on
// every downstream transfer.
module tb_arith_issue;

   typedef struct packed {
      logic        illegal;
      logic [4:0]  rd;
      logic [10:0] ctl;
      logic [31:0] rs2;
      logic [31:0] rs1;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   arith_issue_if #(.bitWidth(32)) io ();
   arith_issue #(.bitWidth(32)) dut (.clk(clk), .reset_n(reset_n), .io(io.slave));

   exp_t sb[$];
   int   errors = 0, checks = 0;
   int   cyc = 0, last_x = -10, run = 0, max_run = 0, stalls = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, want);
      end
   endtask

   function automatic exp_t mk(input logic [10:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      e.illegal = 1'b0; e.rd = rd; e.ctl = c; e.rs2 = b; e.rs1 = a;
      return e;
   endfunction

   function automatic exp_t ill();
      exp_t e = '0;
      e.illegal = 1'b1;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: a transfer happens at the coming posedge when both are high now.
   always @(negedge clk) begin
      if (reset_n && io.ex_valid_o && io.ex_ready_i) begin
         exp_t got, want;
         got = {io.ex_illegal_o, io.ex_rd_o, io.ex_control_o, io.ex_rs2_o, io.ex_rs1_o};
         run = (last_x == cyc - 1) ? run + 1 : 1;
         if (run > max_run) max_run = run;
         last_x = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkt got=%0h want=none", got);
         end else begin
            want = sb.pop_front();
            chk("pkt", 96'(got), 96'(want));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
      int n = 0;
      bit done = 1'b0;
      io.instr_valid_i = 1'b1;
      io.instr_i = ins; io.rs1_data_i = a; io.rs2_data_i = b;
      while (!done) begin
         @(negedge clk);
         if (io.instr_ready_o) begin
            sb.push_back(e);
            done = 1'b1;
         end else begin
            stalls++;
            if (++n > 50) begin
               checks++; errors++;
               $display("FAIL send_timeout got=stalled want=accept");
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      io.instr_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("drained", 96'(sb.size()), 96'd0);
   endtask

   initial begin
      io.flush_i = 0; io.instr_valid_i = 0; io.instr_i = 0;
      io.rs1_data_i = 0; io.rs2_data_i = 0; io.ex_ready_i = 0;
      repeat (2) @(posedge clk); #1;
      chk("rst_valid", 96'(io.ex_valid_o), 96'd0);
      chk("rst_ready", 96'(io.instr_ready_o), 96'd1);
      chk("rst_data", {io.ex_illegal_o, io.ex_rd_o, io.ex_control_o, io.ex_rs2_o, io.ex_rs1_o}, 96'd0);
      reset_n = 1'b1;
      io.ex_ready_i = 1'b1;
      @(posedge clk); #1;

      // directed decode vectors
      send(32'h002081B3, 32'd5,        32'd7, mk(11'h041, 32'd5, 32'd7, 5'd3));          // ADD
      chk("add_latency", 96'(io.ex_valid_o), 96'd1);
      send(32'hFFF00093, 32'd0,        32'd9, mk(11'h041, 32'd0, 32'hFFFFFFFF, 5'd1));   // ADDI -1
      send(32'h4040D113, 32'h80000000, 32'd9, mk(11'h084, 32'h80000000, 32'd4, 5'd2));   // SRAI 4
      send(32'h40208133, 32'd9,        32'd3, mk(11'h042, 32'd9, 32'd3, 5'd2));          // SUB
      send(32'h007312B3, 32'd1,        32'd2, mk(11'h081, 32'd1, 32'd2, 5'd5));          // SLL
      send(32'h0F00F213, 32'hFFFF,     32'd2, mk(11'h044, 32'hFFFF, 32'hF0, 5'd4));      // ANDI
      send(32'h0020A1B3, 32'd4,        32'd6, mk(11'h060, 32'd4, 32'd6, 5'd3));          // SLT
      // illegal packets interleaved with legal ones
      send(32'h002081B3, 32'd1,        32'd1, mk(11'h041, 32'd1, 32'd1, 5'd3));
      send(32'h0020B1B3, 32'd1,        32'd1, ill());                                    // SLTU
      send(32'h022081B3, 32'd1,        32'd1, ill());                                    // MUL
      send(32'h40109093, 32'd1,        32'd1, ill());                                    // SLLI bad f7
      send(32'h002081B3, 32'd2,        32'd2, mk(11'h041, 32'd2, 32'd2, 5'd3));
      drain();

      // backpressure: OR then SK fill, third instruction held upstream
      io.ex_ready_i = 1'b0;
      send(32'h002081B3, 32'd10, 32'd11, mk(11'h041, 32'd10, 32'd11, 5'd3));
      send(32'h40208133, 32'd20, 32'd21, mk(11'h042, 32'd20, 32'd21, 5'd2));
      chk("bp_ready_low", 96'(io.instr_ready_o), 96'd0);
      chk("bp_or_head", 96'(io.ex_rs1_o), 96'd10);
      fork
         send(32'h0020A1B3, 32'd30, 32'd31, mk(11'h060, 32'd30, 32'd31, 5'd3));
         begin
            repeat (3) @(posedge clk); #1;
            chk("bp_held", 96'(io.instr_ready_o), 96'd0);
            max_run = 0;
            io.ex_ready_i = 1'b1;
         end
      join
      drain();
      chk("bp_consecutive", 96'(max_run), 96'd3);

      // full throughput
      max_run = 0; stalls = 0;
      for (int i = 0; i < 10; i++)
         send(32'h002081B3, 32'(i), 32'(3 * i), mk(11'h041, 32'(i), 32'(3 * i), 5'd3));
      drain();
      chk("tp_run", 96'(max_run), 96'd10);
      chk("tp_stalls", 96'(stalls), 96'd0);

      // flush with OR and SK full and an input offered
      io.ex_ready_i = 1'b0;
      send(32'h002081B3, 32'd40, 32'd41, mk(11'h041, 32'd40, 32'd41, 5'd3));
      send(32'h002081B3, 32'd50, 32'd51, mk(11'h041, 32'd50, 32'd51, 5'd3));
      io.instr_valid_i = 1'b1; io.instr_i = 32'h40208133; io.flush_i = 1'b1;
      @(posedge clk); #1;
      io.flush_i = 1'b0; io.instr_valid_i = 1'b0;
      sb.delete();
      chk("flush_valid", 96'(io.ex_valid_o), 96'd0);
      chk("flush_ready", 96'(io.instr_ready_o), 96'd1);
      io.ex_ready_i = 1'b1;
      repeat (4) @(posedge clk); #1;
      send(32'hFFF00093, 32'd0, 32'd0, mk(11'h041, 32'd0, 32'hFFFFFFFF, 5'd1));
      drain();

      // asynchronous reset mid-stream
      io.ex_ready_i = 1'b0;
      send(32'h002081B3, 32'd60, 32'd61, mk(11'h041, 32'd60, 32'd61, 5'd3));
      send(32'h002081B3, 32'd70, 32'd71, mk(11'h041, 32'd70, 32'd71, 5'd3));
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 96'(io.ex_valid_o), 96'd0);
      chk("arst_ready", 96'(io.instr_ready_o), 96'd1);
      chk("arst_data", {io.ex_illegal_o, io.ex_rd_o, io.ex_control_o, io.ex_rs2_o, io.ex_rs1_o}, 96'd0);
      sb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      io.ex_ready_i = 1'b1;
      repeat (4) @(posedge clk); #1;
      send(32'h4040D113, 32'd8, 32'd0, mk(11'h084, 32'd8, 32'd4, 5'd2));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arith_issue.md
Name: arith_issue

Overview:
- Issue stage that feeds the integer arithmetic/shift execute unit (the block with the 11-bit control_i and the rs1_i/rs2_i operand inputs).
- Decodes RV32I OP and OP-IMM instructions into that unit's control word and selects the operands, including immediate substitution.
- Registers the result toward execute through a two-entry skid buffer, so throughput is one instruction per cycle with a registered ready.
- Sits between the decode/register-read stage (upstream valid/ready) and execute (downstream valid/ready).

Parameters:
- bitWidth, 32, operand/data width (XLEN); sign-extension and shamt rules below are defined for 32.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous pipeline flush
- instr_valid_i  input  1  upstream instruction valid
- instr_ready_o  output  1  this block can accept an instruction
- instr_i  input  32  raw instruction word
- rs1_data_i  input  bitWidth  register-file value for instr_i[19:15]
- rs2_data_i  input  bitWidth  register-file value for instr_i[24:20]
- ex_valid_o  output  1  issue packet valid to execute
- ex_ready_i  input  1  execute accepts packet
- ex_rs1_o  output  bitWidth  operand to execute rs1_i
- ex_rs2_o  output  bitWidth  operand to execute rs2_i (register or immediate)
- ex_control_o  output  11  control word to execute control_i
- ex_rd_o  output  5  destination register instr_i[11:7]
- ex_illegal_o  output  1  packet is an unsupported/illegal instruction

Behaviour:
- Control word layout: [5:0] operation, one-hot; [7:6] cmd (01 = ALU result, 10 = shifter result); [10:8] always 0.
- ALU encodings: ADD 0x041, SUB 0x042, AND 0x044, OR 0x048, XOR 0x050, SLT 0x060.
- Shift encodings (operation[2:0] = shift command): SLL 0x081, SRL 0x082, SRA 0x084.
- OP (opcode 0110011), funct7 0000000:
  - funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - ex_rs2_o = rs2_data_i.
- OP, funct7 0100000: funct3 000 SUB, 101 SRA.
- OP-IMM (0010011):
  - funct3 000 ADDI, 010 SLTI, 100 XORI, 110 ORI, 111 ANDI; ex_rs2_o = sign-extended instr_i[31:20].
  - funct3 001 SLLI (funct7 must be 0000000); 101 SRLI (0000000) / SRAI (0100000); ex_rs2_o = zero-extended instr_i[24:20].
- Everything else is illegal: SLTU, SLTIU, M-extension funct7 0000001, other funct7 values, other opcodes.
  - Illegal packet: ex_control_o = 0, ex_rs1_o = ex_rs2_o = 0, ex_illegal_o = 1, ex_rd_o = 0.
  - Illegal packets still flow through the handshake in order, so exceptions stay precise.
- ex_rs1_o = rs1_data_i for every legal instruction.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. Downstream, ex_valid_o stays high and the packet is held stable until ex_ready_i.
- Storage: output register (OR) plus one skid register (SK).
  - instr_ready_o = ~SK.valid, registered. No combinational path from ex_ready_i.
  - Accept while OR empty, or OR draining: the decoded packet goes to OR.
  - Accept while OR full and not draining: the packet goes to SK.
  - When OR drains and SK is full: SK moves to OR, and SK clears.
  - Ordering is strictly FIFO. Latency is 1 cycle from accept to ex_valid_o when empty.
- Simultaneous accept and drain with SK empty: OR is replaced, ex_valid_o stays 1, no bubble.
- Full (SK valid): instr_ready_o = 0 and instr_valid_i is ignored.
- flush_i = 1 (priority over everything, synchronous):
  - Next cycle: OR and SK are invalid, ex_valid_o = 0, instr_ready_o = 1.
  - An input offered in the flush cycle is dropped.
- Reset (asynchronous, any time including mid-transfer):
  - ex_valid_o = 0, instr_ready_o = 1.
  - ex_rs1_o, ex_rs2_o, ex_control_o, ex_rd_o, ex_illegal_o = 0, and SK is cleared.
- Data registers load only on transfer; no X propagation from an invalid input.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, ex_ready_i = 1 -> next cycle ex_valid_o = 1, ex_control_o = 0x041, ex_rs1_o = 5, ex_rs2_o = 7, ex_rd_o = 3.
- ADDI x1,x0,-1 (0xFFF00093) -> ex_rs2_o = 0xFFFFFFFF, control 0x041.
  - SRAI x2,x1,4 (0x4040D113) -> ex_rs2_o = 4, control 0x084.
  - SUB (0x40208133) -> control 0x042.
- Backpressure: stream 3 instructions with ex_ready_i = 0.
  - Required: OR then SK fill; instr_ready_o = 0 after the 2nd accept; 3rd is held by upstream.
  - Then raise ex_ready_i -> packets emerge in order on consecutive cycles, no loss or duplication.
- Full throughput: ex_ready_i = 1 and back-to-back valid for 10 cycles -> 10 packets on 10 consecutive cycles, instr_ready_o never 0.
- Illegal: SLTU (0x0020B1B3) and MUL (0x022081B3) -> ex_illegal_o = 1, control 0, still handshaken in order between legal packets.
- Flush with OR and SK full and an input offered -> next cycle ex_valid_o = 0, instr_ready_o = 1, none of the three ever appear.
  - Repeat with reset_n pulsed low mid-stream -> all outputs go 0 immediately (asynchronously).
